// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the parameterised serial pattern detector:
// state register width and the prefix/suffix next-state rule.
package seq_det_pkg;

  localparam int MAXN = 16;

  function automatic int state_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Next state from Sk on input bit x. Bit i of the serial pattern is pat[n-1-i].
  function automatic int next_state(input logic [MAXN-1:0] pat, input int n,
                                    input int k, input logic x, input bit ovl);
    logic [MAXN:0] s;
    int            len;
    int            best;
    bit            ok;
    if (k < n && x == pat[n-1-k]) return k + 1;
    if (k >= n && !ovl) return (x == pat[n-1]) ? 1 : 0;
    len = ((k >= n) ? n : k) + 1;
    s   = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < len - 1) s[i] = pat[n-1-i];
    end
    s[len-1] = x;
    best = 0;
    // From SN a full-length suffix may equal the pattern itself (constant
    // patterns); staying in SN keeps every sliding-window match visible.
    for (int j = 1; j <= MAXN; j++) begin
      if (j <= n && j < len) begin
        ok = 1'b1;
        for (int i = 0; i < MAXN; i++) begin
          if (i < j && s[len-j+i] != pat[n-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear coincident with a new match keeps that match.
module seq_match_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc && cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector: S0..SN track the longest matched pattern prefix,
// with a transition table built from PATTERN at elaboration time.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1001,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x,
  input  logic          en,
  input  logic          clr,
  output logic          z,
  output logic [CW-1:0] match_cnt
);

  localparam int              SW      = state_w(N);
  localparam logic [MAXN-1:0] PAT_EXT = MAXN'(PATTERN);

  typedef logic [SW-1:0] state_t;

  state_t nxt_tbl [0:N][0:1];
  state_t state;
  state_t state_nxt;
  logic   state_ok;
  logic   hit;

  for (genvar k = 0; k <= N; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NS = next_state(PAT_EXT, N, k, (b == 1), OVERLAP);
      assign nxt_tbl[k][b] = SW'(NS);
    end
  end

  always_comb begin
    state_ok  = (state <= SW'(N));
    state_nxt = '0;
    if (state_ok) state_nxt = nxt_tbl[state][x];
    hit = en && state_ok && (state_nxt == SW'(N));
  end

  // Out-of-range encodings fall back to S0 regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      z     <= 1'b0;
    end else if (!state_ok) begin
      state <= '0;
      z     <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      z     <= (state_nxt == SW'(N));
    end
  end

  seq_match_counter #(.CW(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (hit),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five parameterisations share one input stream and
// are compared against a sliding-window model of the sampled bit history.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x   = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic       z_def, z_nov, z_sat, z_p5o, z_p5n;
  logic [7:0] cnt_def, cnt_nov, cnt_p5o, cnt_p5n;
  logic [1:0] cnt_sat;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_param u_def (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .z(z_def), .match_cnt(cnt_def));
  seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .z(z_nov), .match_cnt(cnt_nov));
  seq_detector_param #(.CW(2)) u_sat (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .z(z_sat), .match_cnt(cnt_sat));
  seq_detector_param #(.N(5), .PATTERN(5'b11011), .OVERLAP(1'b1)) u_p5o (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .z(z_p5o), .match_cnt(cnt_p5o));
  seq_detector_param #(.N(5), .PATTERN(5'b11011), .OVERLAP(1'b0)) u_p5n (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .z(z_p5n), .match_cnt(cnt_p5n));

  // Model: 0=def 1=nov 2=sat 3=p5o 4=p5n
  int          mn   [5] = '{4, 4, 4, 5, 5};
  logic [15:0] mp   [5] = '{16'b1001, 16'b1001, 16'b1001, 16'b11011, 16'b11011};
  bit          movl [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int          mmax [5] = '{255, 255, 3, 255, 255};
  int          mlast[5];
  int          mcnt [5];
  bit          mz   [5];
  bit          hist [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 5; m++) begin
      mlast[m] = 0;
      mcnt[m]  = 0;
      mz[m]    = 1'b0;
    end
  endtask

  // A match is the last N sampled bits equalling the pattern; without overlap
  // the window must also lie entirely after the previous match.
  task automatic model_step(input bit xv, input bit env, input bit clrv);
    int len;
    bit hitm;
    if (env) hist.push_back(xv);
    len = hist.size();
    for (int m = 0; m < 5; m++) begin
      hitm = 1'b0;
      if (env && len >= mn[m]) begin
        hitm = 1'b1;
        for (int i = 0; i < mn[m]; i++)
          if (hist[len-mn[m]+i] != mp[m][mn[m]-1-i]) hitm = 1'b0;
        if (!movl[m] && (len - mlast[m]) < mn[m]) hitm = 1'b0;
      end
      if (hitm) mlast[m] = len;
      if (env) mz[m] = hitm;
      if (clrv) mcnt[m] = hitm ? 1 : 0;
      else if (hitm && mcnt[m] < mmax[m]) mcnt[m]++;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "/def_z"},   z_def,   mz[0]);
    chk({ctx, "/def_cnt"}, cnt_def, mcnt[0]);
    chk({ctx, "/nov_z"},   z_nov,   mz[1]);
    chk({ctx, "/nov_cnt"}, cnt_nov, mcnt[1]);
    chk({ctx, "/sat_z"},   z_sat,   mz[2]);
    chk({ctx, "/sat_cnt"}, cnt_sat, mcnt[2]);
    chk({ctx, "/p5o_z"},   z_p5o,   mz[3]);
    chk({ctx, "/p5o_cnt"}, cnt_p5o, mcnt[3]);
    chk({ctx, "/p5n_z"},   z_p5n,   mz[4]);
    chk({ctx, "/p5n_cnt"}, cnt_p5n, mcnt[4]);
  endtask

  task automatic step(input string ctx, input bit xv, input bit env, input bit clrv);
    x   = xv;
    en  = env;
    clr = clrv;
    @(posedge clk);
    #1;
    model_step(xv, env, clrv);
    check_all(ctx);
  endtask

  // Inputs other than rst are kept busy to show reset priority.
  task automatic do_reset(input string ctx);
    rst = 1'b1;
    x   = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all(ctx);
  endtask

  initial begin
    bit seq7 [7] = '{1, 0, 0, 1, 0, 0, 1};

    do_reset("reset");
    chk("reset_z", z_def, 0);
    chk("reset_cnt", cnt_def, 0);

    // Overlapping vs non-overlapping on 1001001
    for (int i = 0; i < 7; i++) begin
      step("ovl", seq7[i], 1'b1, 1'b0);
      if (i == 3) begin
        chk("ovl_z_bit4", z_def, 1);
        chk("nov_z_bit4", z_nov, 1);
      end
    end
    chk("ovl_z_bit7", z_def, 1);
    chk("ovl_cnt", cnt_def, 2);
    chk("nov_z_bit7", z_nov, 0);
    chk("nov_cnt", cnt_nov, 1);

    // en gating: 1,0, three idle cycles with x toggling, then 0,1
    do_reset("reset_en");
    step("gate", 1'b1, 1'b1, 1'b0);
    step("gate", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("gate_idle", i[0], 1'b0, 1'b0);
      chk("gate_idle_z", z_def, 0);
    end
    step("gate", 1'b0, 1'b1, 1'b0);
    step("gate", 1'b1, 1'b1, 1'b0);
    chk("gate_z", z_def, 1);
    chk("gate_cnt", cnt_def, 1);
    step("gate_hold", 1'b0, 1'b0, 1'b0);
    chk("gate_hold_z", z_def, 1);

    // Saturation at 3, then clr with and without a coincident match
    do_reset("reset_sat");
    step("sat", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("sat", (i % 3) == 2, 1'b1, 1'b0);
    chk("sat_cnt", cnt_sat, 3);
    chk("sat_def_cnt", cnt_def, 5);
    step("sat", 1'b0, 1'b1, 1'b0);
    step("sat", 1'b0, 1'b1, 1'b0);
    step("clr_hit", 1'b1, 1'b1, 1'b1);
    chk("clr_hit_cnt", cnt_sat, 1);
    step("clr_only", 1'b0, 1'b1, 1'b1);
    chk("clr_only_cnt", cnt_sat, 0);

    // Reset mid-pattern discards the 1,0,0 prefix
    do_reset("reset_mid0");
    step("mid", 1'b1, 1'b1, 1'b0);
    step("mid", 1'b0, 1'b1, 1'b0);
    step("mid", 1'b0, 1'b1, 1'b0);
    do_reset("reset_mid1");
    step("mid", 1'b1, 1'b1, 1'b0);
    chk("mid_z", z_def, 0);
    chk("mid_cnt", cnt_def, 0);

    // Random stream for all parameterisations
    do_reset("reset_rand");
    for (int i = 0; i < 2000; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
           $urandom_range(0, 49) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the pattern length (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1001 (N bits); PATTERN[N-1] is the first serial bit expected.
REQ-003 The block SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 The block SHALL have parameter CW, default 8, giving the match counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port x, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port en, input, 1 bit: x is sampled only when en=1.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of match_cnt.
REQ-010 The block SHALL have port z, output, 1 bit: Moore match flag.
REQ-011 The block SHALL have port match_cnt, output, CW bits: saturating count of detected matches.

Function
REQ-012 The FSM SHALL have N+1 states S0..SN; Sk means the last k sampled bits equal the first k bits of PATTERN, and SN is the match state.
REQ-013 From Sk (k<N) on an en cycle, the next state SHALL be Sk+1 if x equals the expected bit PATTERN[N-1-k].
REQ-014 Otherwise from Sk, the next state SHALL be Sj, where j is the longest proper prefix of PATTERN that is a suffix of (first k bits, x).
REQ-015 From SN with OVERLAP=1, the next state SHALL be Sj, where j is the longest proper prefix of PATTERN that is a suffix of (PATTERN, x).
REQ-016 From SN with OVERLAP=0, the next state SHALL be S1 if x==PATTERN[N-1], else S0.
REQ-017 Transition tables SHALL be derived at elaboration time from PATTERN and N; no per-pattern hand coding.
REQ-018 z SHALL be a function of state only: 1 exactly while in SN, 0 otherwise.
REQ-019 Latency SHALL be 1 clock: z rises in the cycle after the edge that samples the final pattern bit.
REQ-020 On en=0, state, z and match_cnt SHALL hold; x is ignored.
REQ-021 match_cnt SHALL increment on each edge where en=1 and the next state is SN.
REQ-022 match_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-023 clr=1 with no increment that edge SHALL load match_cnt with 0.
REQ-024 clr=1 coincident with an increment SHALL load match_cnt with 1, so the match is not lost.
REQ-025 Any unreachable state encoding SHALL return to S0 on the next edge, with z=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force S0, z=0 and match_cnt=0, taking priority over en, clr and x.
REQ-027 rst asserted mid-pattern SHALL discard partial progress; detection restarts from S0 on the first en cycle after rst deasserts.
REQ-028 No asynchronous reset path SHALL exist.

Structure
REQ-029 Package seq_det_pkg SHALL hold the state-width function (clog2 of N+1) and the elaboration-time prefix/suffix next-state function.
REQ-030 The saturating counter with clr/increment priority SHALL be a sub-module seq_match_counter (parameter CW).
REQ-031 The state register, next-state logic and Moore output SHALL reside in seq_detector_param.

Verification
REQ-032 Overlap: defaults, en=1, x=1,0,0,1,0,0,1 -> z=1 in the cycle after the 4th bit and after the 7th bit; match_cnt=2.
REQ-033 Non-overlap: OVERLAP=0, same stream -> z=1 only after the 4th bit; match_cnt=1.
REQ-034 en gating: 1,0,en=0 for 3 cycles with x toggling, then 0,1 -> a single match; z and state frozen during the en=0 cycles.
REQ-035 Saturation and clr: CW=2, 5 overlapping matches -> match_cnt stops at 3; clr coincident with a match -> match_cnt=1; clr alone -> match_cnt=0.
REQ-036 Reset mid-operation: rst after 1,0,0, then x=1 -> no match (z=0, match_cnt=0).
REQ-037 Parameter sweep: N=5, PATTERN=5'b11011, random 2000-bit stream -> z and match_cnt match a software sliding-window model, in both OVERLAP modes.
